// File: rtl/clock_edge_monitor.sv
// Samples a slow clock into clk_in, emits edge strobes,
// measures period/high time and tracks period lock.
//
// Ports:
//   clk_in        system clock (only clock)
//   rst_n         async active-low reset
//   slow_clk      asynchronous slow clock input
//   slow_clk_sync synchronized slow_clk level
//   slow_rising   1-cycle strobe, synced rising edge
//   slow_falling  1-cycle strobe, synced falling edge
//   period        last rise-to-rise distance
//   high_time     last rise-to-fall distance
//   period_valid  1-cycle pulse when period updates
//   locked        period stable within Tolerance
//   timeout       no rising edge for 2^CountWidth-1 cycles
module clock_edge_monitor #(
  parameter int CountWidth = 16,
  parameter int SyncStages = 2,
  parameter int LockCount  = 4,
  parameter int Tolerance  = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  slow_clk,
  output logic                  slow_clk_sync,
  output logic                  slow_rising,
  output logic                  slow_falling,
  output logic [CountWidth-1:0] period,
  output logic [CountWidth-1:0] high_time,
  output logic                  period_valid,
  output logic                  locked,
  output logic                  timeout
);

  localparam int McntW = $clog2(LockCount + 1);

  localparam logic [CountWidth-1:0] CntMax = '1;
  localparam logic [CountWidth-1:0] CntOne =
    CountWidth'(1);
  localparam logic [CountWidth:0] TolV =
    (CountWidth + 1)'(Tolerance);
  localparam logic [CountWidth:0] DiffOne =
    (CountWidth + 1)'(1);
  localparam logic [McntW-1:0] LockTgt =
    McntW'(LockCount);
  localparam logic [McntW-1:0] McntOne =
    McntW'(1);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    ACQUIRE,
    LOCKED
  } state_t;

  logic [SyncStages-1:0] sync_q;
  logic                  hist_q;
  logic                  sync_last;
  logic                  rise_d;
  logic                  fall_d;

  logic [CountWidth-1:0] cnt_q;
  logic                  cnt_sat;
  logic                  sat_hit;
  logic                  seen_q;

  logic [CountWidth:0]   diff;
  logic [CountWidth:0]   adiff;
  logic                  match;

  state_t                state_q;
  state_t                state_d;
  logic [McntW-1:0]      mcnt_q;
  logic [McntW-1:0]      mcnt_d;
  logic [McntW-1:0]      mcnt_inc;
  logic                  load;

  logic                  locked_d;
  logic                  timeout_d;
  logic                  high_ld;

  // hist_q is both the edge-detect history and
  // the synchronized level, so they stay aligned
  assign sync_last     = sync_q[SyncStages-1];
  assign rise_d        = sync_last & ~hist_q;
  assign fall_d        = ~sync_last & hist_q;
  assign slow_clk_sync = hist_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], slow_clk};
      hist_q <= sync_last;
    end
  end

  // Restart at 1 so the value seen at the next
  // rise equals the rise-to-rise distance
  assign cnt_sat = (cnt_q == CntMax);
  assign sat_hit = cnt_sat & ~rise_d;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      if (rise_d) begin
        cnt_q <= CntOne;
      end else if (!cnt_sat) begin
        cnt_q <= cnt_q + CntOne;
      end
      if (rise_d) begin
        seen_q <= 1'b1;
      end else if (sat_hit) begin
        seen_q <= 1'b0;
      end
    end
  end

  // One extra bit keeps the signed difference exact
  always_comb begin
    diff  = {1'b0, cnt_q} - {1'b0, period};
    adiff = diff[CountWidth] ? (~diff + DiffOne)
                             : diff;
    match = (adiff <= TolV);
  end

  assign mcnt_inc = mcnt_q + McntOne;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    load    = 1'b0;
    if (rise_d) begin
      unique case (state_q)
        IDLE: begin
          state_d = FIRST;
        end
        FIRST: begin
          state_d = ACQUIRE;
          mcnt_d  = '0;
          load    = 1'b1;
        end
        ACQUIRE: begin
          load = 1'b1;
          if (match) begin
            mcnt_d = mcnt_inc;
            if (mcnt_inc == LockTgt) begin
              state_d = LOCKED;
            end
          end else begin
            mcnt_d = '0;
          end
        end
        LOCKED: begin
          load = 1'b1;
          if (!match) begin
            state_d = ACQUIRE;
            mcnt_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          mcnt_d  = '0;
        end
      endcase
    end else if (sat_hit) begin
      state_d = IDLE;
      mcnt_d  = '0;
    end
  end

  always_comb begin
    locked_d  = (state_d == LOCKED);
    timeout_d = timeout;
    if (rise_d) begin
      timeout_d = 1'b0;
    end else if (sat_hit) begin
      timeout_d = 1'b1;
    end
    high_ld = fall_d & seen_q;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      slow_rising  <= 1'b0;
      slow_falling <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      slow_rising  <= rise_d;
      slow_falling <= fall_d;
      period_valid <= load;
      locked       <= locked_d;
      timeout      <= timeout_d;
      if (load) begin
        period <= cnt_q;
      end
      if (high_ld) begin
        high_time <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Randomized bench for clock_edge_monitor with an
// event-level reference model of edges and lock.
module tb_clock_edge_monitor;

  localparam int CW   = 8;
  localparam int Max  = 255;
  localparam int LckN = 4;
  localparam int Tol  = 1;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          slow_clk;
  logic          slow_clk_sync;
  logic          slow_rising;
  logic          slow_falling;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic          locked;
  logic          timeout;

  clock_edge_monitor #(
    .CountWidth(CW),
    .SyncStages(2),
    .LockCount (LckN),
    .Tolerance (Tol)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .slow_clk     (slow_clk),
    .slow_clk_sync(slow_clk_sync),
    .slow_rising  (slow_rising),
    .slow_falling (slow_falling),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: cycle index k, cycle of last rise r,
  // rises since idle, run of consecutive matches
  logic [3:0] smp;
  int  k, r, nrise, run, prevp;
  bit  seen;
  bit  e_sync, e_rise, e_fall, e_pv, e_lock, e_to;
  int  e_per, e_high;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d want %0d at %0t",
                 tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    smp = '0;
    k = 0; r = 1;
    nrise = 0; run = 0; prevp = 0;
    seen = 0;
    e_sync = 0; e_rise = 0; e_fall = 0;
    e_pv = 0; e_lock = 0; e_to = 0;
    e_per = 0; e_high = 0;
  endtask

  task automatic model_step(input logic v);
    int gap, d;
    k++;
    smp    = {smp[2:0], v};
    e_sync = smp[2];
    e_rise = smp[2] & ~smp[3];
    e_fall = ~smp[2] & smp[3];
    e_pv   = 0;
    gap    = (k - r > Max) ? Max : k - r;
    if (e_fall && seen) e_high = gap;
    if (e_rise) begin
      e_to = 0;
      if (nrise >= 1) begin
        e_pv  = 1;
        e_per = gap;
        d = gap - prevp;
        if (d < 0) d = -d;
        if (nrise >= 2 && d <= Tol) run++;
        else run = 0;
        prevp = gap;
      end
      nrise++;
      r    = k;
      seen = 1;
    end else if (k - r >= Max) begin
      nrise = 0;
      run   = 0;
      e_to  = 1;
      seen  = 0;
    end
    e_lock = (run >= LckN);
  endtask

  task automatic compare_all();
    check("sync", int'(slow_clk_sync), int'(e_sync));
    check("rise", int'(slow_rising), int'(e_rise));
    check("fall", int'(slow_falling), int'(e_fall));
    check("excl", int'(slow_rising & slow_falling), 0);
    check("period", int'(period), e_per);
    check("high", int'(high_time), e_high);
    check("pvalid", int'(period_valid), int'(e_pv));
    check("locked", int'(locked), int'(e_lock));
    check("timeout", int'(timeout), int'(e_to));
  endtask

  // called at a negedge; returns at the next negedge
  task automatic tick(input logic v);
    slow_clk = v;
    @(posedge clk_in);
    if (rst_n) model_step(v);
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  task automatic cycles(input int hi, input int lo,
                        input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  initial begin
    int hi, lo, len;
    rst_n    = 1'b0;
    slow_clk = 1'b0;
    model_reset();
    repeat (5) begin
      @(negedge clk_in);
      compare_all();
    end
    rst_n = 1'b1;

    drive(1'b0, 4);
    cycles(8, 8, 8);
    check("steady_per", int'(period), 16);
    check("steady_high", int'(high_time), 8);
    check("steady_lock", int'(locked), 1);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8);
      drive(1'b0, 8 + (i % 2));
    end
    check("jitter_lock", int'(locked), 1);

    cycles(10, 10, 6);
    check("rate_per", int'(period), 20);
    check("rate_lock", int'(locked), 1);

    drive(1'b0, 300);
    check("to_flag", int'(timeout), 1);
    check("to_lock", int'(locked), 0);
    cycles(8, 8, 8);
    check("relock", int'(locked), 1);
    check("relock_to", int'(timeout), 0);

    slow_clk = 1'b1;
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk_in);
    drive(1'b1, 2);
    drive(1'b0, 3);
    rst_n = 1'b1;
    drive(1'b0, 2);
    cycles(8, 8, 8);
    check("rst_relock", int'(locked), 1);

    cycles(3, 3, 10);
    check("min_per", int'(period), 6);
    check("min_high", int'(high_time), 3);
    check("min_lock", int'(locked), 1);

    for (int b = 0; b < 25; b++) begin
      hi  = $urandom_range(3, 14);
      lo  = $urandom_range(3, 14);
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        drive(1'b1, hi);
        drive(1'b0, lo + int'($urandom_range(0, 1)));
      end
    end
    drive(1'b1, 2);
    drive(1'b0, 2);
    drive(1'b0, 270);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_edge_monitor.md
# clock_edge_monitor

Receive-side counterpart to the power-of-two clock dividers. The block takes a slow clock from an external source or another domain and samples it into the `clk_in` domain. It produces single-cycle rising and falling strobes, measures the slow clock's period and high time in `clk_in` cycles, and reports lock once the period is stable. Downstream consumers such as the audio and bit-clock logic use its strobes as clock enables instead of clocking from the slow clock directly.

## Interface
- `CountWidth`, 16: width of the period/high-time counters and outputs.
- `SyncStages`, 2: synchronizer flops on `slow_clk`; must be ≥2.
- `LockCount`, 4: consecutive matching period measurements required to assert `locked`.
- `Tolerance`, 1: maximum |difference| in cycles between consecutive periods that still counts as a match.

Ports:
- `clk_in` input 1: system clock; the only clock in the block.
- `rst_n` input 1: asynchronous, active-low reset.
- `slow_clk` input 1: asynchronous slow clock being monitored.
- `slow_clk_sync` output 1: synchronized level of `slow_clk`.
- `slow_rising` output 1: one-cycle strobe marking a synchronized rising edge.
- `slow_falling` output 1: one-cycle strobe marking a synchronized falling edge.
- `period` output CountWidth: last measured rise-to-rise distance, in `clk_in` cycles.
- `high_time` output CountWidth: last measured rise-to-fall distance, in `clk_in` cycles.
- `period_valid` output 1: one-cycle pulse when `period` updates.
- `locked` output 1: period is stable within `Tolerance`.
- `timeout` output 1: no rising edge seen for 2^CountWidth−1 cycles.

## Operation
- **Synchronizer:** chain of `SyncStages` flops plus one history flop, all reset to 0.
    - `slow_rising` is registered: high when last stage = 1 and history = 0.
    - `slow_falling` is registered: high when last stage = 0 and history = 1.
    - The strobes are mutually exclusive.
- **Period counter:** increments every cycle and saturates at 2^CountWidth−1.
    - On each `slow_rising` it restarts, so that rising strobes at cycles t and t+N give a measurement of exactly N.
- **High-time counter:** restarts on `slow_rising`.
    - On `slow_falling`, `high_time` is loaded with the cycles elapsed since the last `slow_rising`.
    - A falling strobe before any rising strobe is ignored.
- **State machine:** states IDLE, FIRST, ACQUIRE, LOCKED; match counter `mcnt`.
    - IDLE → FIRST on `slow_rising`. No measurement is made.
    - FIRST → ACQUIRE on `slow_rising`. `period` is loaded, `period_valid` pulses, and `mcnt` is set to 0.
    - ACQUIRE, on `slow_rising`: `period` is loaded and `period_valid` pulses.
        - On a match (|new − previous `period`| ≤ Tolerance), `mcnt` increments. When `mcnt` reaches `LockCount`, go to LOCKED.
        - On a mismatch, `mcnt` is set to 0.
    - LOCKED, on `slow_rising`: `period` is loaded and `period_valid` pulses. A mismatch goes to ACQUIRE with `mcnt` = 0.
    - Any state: when the period counter saturates, go to IDLE and set `timeout` = 1.
- **`locked`:** equals (state == LOCKED), registered.
- **`timeout`:** clears on the next `slow_rising`, which moves the state IDLE → FIRST and makes no measurement.
- **Width rules:**
    - The difference comparison uses CountWidth+1 bits, so no wrap occurs.
    - A saturated count is never reported as a `period`.
- **Simultaneous events:** if saturation and `slow_rising` occur in the same cycle, `slow_rising` wins. A normal measurement is taken and `timeout` stays 0.

## Timing
- **Reset values:** all outputs are 0, the state is IDLE, `mcnt` = 0, and all counters are 0. `rst_n` low mid-operation clears everything immediately, independent of `clk_in`.
- **Strobe latency:** a `slow_clk` transition captured at `clk_in` edge E0 drives `slow_rising`/`slow_falling` high for the single cycle after edge E0+SyncStages.
- **Output alignment:** these all update at the same clock edge that sets the corresponding strobe:
    - `slow_clk_sync`
    - `period` and `period_valid`
    - `high_time`
    - `locked`
- **Lock timing:** `locked` rises together with the `period_valid` of the (LockCount+2)-th rising strobe after IDLE. `locked` falls together with the `period_valid` that carries the first mismatching period.
- **Minimum input:** the supported slow clock has high and low phases of ≥ SyncStages+1 `clk_in` cycles each. Shorter pulses may be dropped, but must never produce both strobes in one cycle.

## Test plan
- **Reset:** hold `rst_n` low for 5 cycles, then release with `slow_clk` = 0. Required: all outputs 0, no strobes, `locked` = 0.
- **Steady clock:** `slow_clk` with period 16 cycles, 8 high. Required:
    - First `slow_rising` appears 3 cycles after the capturing edge.
    - From the 2nd rising strobe onward, `period` = 16 with `period_valid` pulses.
    - `high_time` = 8.
    - `locked` = 1 at the 6th rising strobe.
- **Jitter and rate change:**
    - Periods alternating 16/17: `locked` stays 1.
    - Switch to period 20: `locked` drops on the first `period` = 20, then returns at the 4th subsequent matching period.
- **Timeout (CountWidth = 8):** stop `slow_clk` while locked. Required:
    - `timeout` = 1 and `locked` = 0 exactly 255 cycles after the last rising strobe.
    - After restarting the clock, the first rising strobe clears `timeout` without `period_valid`.
    - The second rising strobe gives `period_valid`.
- **Reset while locked:** assert `rst_n` low asynchronously. Required: all outputs 0 at once. After release, the lock sequence repeats from IDLE.
- **Minimum pulse:** `slow_clk` with 3-cycle high and 3-cycle low phases. Required: `period` = 6, `high_time` = 3, `locked` asserted, and strobes never coincide.
